// File: rtl/branch_predict_ctrl_pkg.sv
// Shared constants for the branch predictor: counter encodings, the counter
// reset value and the delay-slot skip used on a not-taken recovery.
package branch_predict_ctrl_pkg;

  localparam int unsigned CTR_W = 2;

  typedef logic [CTR_W-1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SNT = 2'b00;
  localparam bp_ctr_t BP_WNT = 2'b01;
  localparam bp_ctr_t BP_WT  = 2'b10;
  localparam bp_ctr_t BP_ST  = 2'b11;

  localparam bp_ctr_t BP_CTR_RST = BP_WNT;

  localparam logic [31:0] BP_DS_OFFSET = 32'd8;

endpackage

// File: rtl/branch_predict_ctrl_bp_sat_ctr2.sv
// bp_sat_ctr2: combinational 2-bit saturating counter update.
// Ports:
//   ctr_i   - current counter value
//   taken_i - resolved direction (1 = count up, 0 = count down)
//   ctr_o   - next counter value, saturating at BP_ST / BP_SNT
module bp_sat_ctr2
  import branch_predict_ctrl_pkg::*;
(
  input  bp_ctr_t ctr_i,
  input  logic    taken_i,
  output bp_ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != BP_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != BP_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit counter branch predictor with misprediction
// recovery for the 5-stage MIPS pipeline.
// Configuration macro: BP_GSHARE_EN (defined = gshare index with speculative
// global history; undefined = bimodal, no history registers).
// Ports:
//   clk, resetn                 - clock, async active-low reset
//   stall_D, stall_E            - stage hold signals
//   branch_D, pc_D              - D-stage branch and its PC
//   pred_take_D, ghr_snap_D     - prediction and history used for it
//   branch_E, pc_E, target_E    - E-stage branch, its PC and target
//   ghr_snap_E                  - history snapshot carried from D
//   actual_take_E, pre_right_E  - branch-check results
//   redirect_E, redirect_pc_E   - fetch redirect on mispredict
//   flush_D                     - kill wrong-path instruction in D
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 10,
  parameter int unsigned GHR_W     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall_D,
  input  logic              stall_E,
  input  logic              branch_D,
  input  logic [31:0]       pc_D,
  output logic              pred_take_D,
  output logic [GHR_W-1:0]  ghr_snap_D,
  input  logic              branch_E,
  input  logic [31:0]       pc_E,
  input  logic [31:0]       target_E,
  input  logic [GHR_W-1:0]  ghr_snap_E,
  input  logic              actual_take_E,
  input  logic              pre_right_E,
  output logic              redirect_E,
  output logic [31:0]       redirect_pc_E,
  output logic              flush_D
);

  localparam int unsigned BHT_DEPTH = 1 << BHT_IDX_W;

  bp_ctr_t                ctr_q [BHT_DEPTH];
  bp_ctr_t                ctr_cur;
  bp_ctr_t                ctr_nxt;
  logic [BHT_IDX_W-1:0]   idx_D;
  logic [BHT_IDX_W-1:0]   idx_E;
  logic                   train;
  logic                   mis;
  logic                   unused_bits;

  // Training and recovery only happen when E actually advances. Redirect is
  // also gated by reset so it falls immediately when reset is asserted.
  assign train = branch_E & ~stall_E;
  assign mis   = resetn & train & ~pre_right_E;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  // History folds into the low index bits only.
  assign idx_D = pc_D[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);
  assign idx_E = pc_E[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_snap_E);
  assign ghr_snap_D = ghr_q;

  // Recovery from the older E branch overrides the younger D shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mis) begin
      ghr_d = {ghr_snap_E[GHR_W-2:0], actual_take_E};
    end else if (branch_D && !stall_D) begin
      ghr_d = {ghr_q[GHR_W-2:0], pred_take_D};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ghr_q <= '0;
    else         ghr_q <= ghr_d;
  end

  assign unused_bits = ^{pc_D[31:BHT_IDX_W+2], pc_D[1:0]};
`else
  assign idx_D      = pc_D[BHT_IDX_W+1:2];
  assign idx_E      = pc_E[BHT_IDX_W+1:2];
  assign ghr_snap_D = '0;

  assign unused_bits = ^{pc_D[31:BHT_IDX_W+2], pc_D[1:0], ghr_snap_E, stall_D};
`endif

  // Prediction reads the registered table: no bypass from same-cycle training.
  assign pred_take_D = branch_D & ctr_q[idx_D][1];
  assign ctr_cur     = ctr_q[idx_E];

  bp_sat_ctr2 u_sat_ctr2 (
    .ctr_i   (ctr_cur),
    .taken_i (actual_take_E),
    .ctr_o   (ctr_nxt)
  );

  // Counter table
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= BP_CTR_RST;
    end else if (train) begin
      ctr_q[idx_E] <= ctr_nxt;
    end
  end

  // Redirect: taken goes to target, not-taken skips branch and delay slot.
  assign redirect_E    = mis;
  assign flush_D       = mis;
  assign redirect_pc_E = mis ? (actual_take_E ? target_E : pc_E + BP_DS_OFFSET) : 32'd0;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl against a table/history model.
module tb_branch_predict_ctrl;

  localparam int unsigned IDX_W = 10;
  localparam int unsigned GW    = 8;
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic          clk = 1'b0;
  logic          resetn;
  logic          stall_D, stall_E, branch_D, branch_E;
  logic [31:0]   pc_D, pc_E, target_E;
  logic          pred_take_D;
  logic [GW-1:0] ghr_snap_D, ghr_snap_E;
  logic          actual_take_E, pre_right_E;
  logic          redirect_E, flush_D;
  logic [31:0]   redirect_pc_E;

  int checks = 0;
  int errors = 0;

  int unsigned m_ctr [DEPTH];
  int unsigned m_ghr;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.BHT_IDX_W(IDX_W), .GHR_W(GW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stall_D       (stall_D),
    .stall_E       (stall_E),
    .branch_D      (branch_D),
    .pc_D          (pc_D),
    .pred_take_D   (pred_take_D),
    .ghr_snap_D    (ghr_snap_D),
    .branch_E      (branch_E),
    .pc_E          (pc_E),
    .target_E      (target_E),
    .ghr_snap_E    (ghr_snap_E),
    .actual_take_E (actual_take_E),
    .pre_right_E   (pre_right_E),
    .redirect_E    (redirect_E),
    .redirect_pc_E (redirect_pc_E),
    .flush_D       (flush_D)
  );

  function automatic int unsigned m_idx(input logic [31:0] pc, input int unsigned h);
    int unsigned i;
    i = (pc >> 2) % DEPTH;
`ifdef BP_GSHARE_EN
    i = i ^ (h % (1 << GW));
`endif
    return i;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_ctr[i] = 1;
    m_ghr = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive, check combinational outputs, clock, update model.
  task automatic cycle(input logic bd, input logic [31:0] pcd, input logic be,
                       input logic [31:0] pce, input logic [31:0] tgt,
                       input logic [GW-1:0] snap, input logic act, input logic pr,
                       input logic sd, input logic se);
    logic        e_pred, e_mis;
    logic [31:0] e_rpc;
    int unsigned ie;
    branch_D = bd; pc_D = pcd; branch_E = be; pc_E = pce; target_E = tgt;
    ghr_snap_E = snap; actual_take_E = act; pre_right_E = pr;
    stall_D = sd; stall_E = se;
    #2;
    e_pred = bd && (m_ctr[m_idx(pcd, m_ghr)] >= 2);
    e_mis  = be && !se && !pr;
    e_rpc  = e_mis ? (act ? tgt : pce + 32'd8) : 32'd0;
    check("pred_take_D", 32'(pred_take_D), 32'(e_pred));
    check("ghr_snap_D", 32'(ghr_snap_D), m_ghr);
    check("redirect_E", 32'(redirect_E), 32'(e_mis));
    check("flush_D", 32'(flush_D), 32'(e_mis));
    check("redirect_pc_E", redirect_pc_E, e_rpc);
    @(posedge clk);
    if (be && !se) begin
      ie = m_idx(pce, 32'(snap));
      if (act) m_ctr[ie] = (m_ctr[ie] == 3) ? 3 : m_ctr[ie] + 1;
      else     m_ctr[ie] = (m_ctr[ie] == 0) ? 0 : m_ctr[ie] - 1;
    end
`ifdef BP_GSHARE_EN
    if (e_mis) m_ghr = ((32'(snap) << 1) | 32'(act)) % (1 << GW);
    else if (bd && !sd) m_ghr = ((m_ghr << 1) | 32'(e_pred)) % (1 << GW);
`endif
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc_r, pc_e;
    logic [31:0] pc_hit;
    model_reset();
    resetn = 1'b0;
    branch_D = 1'b1; pc_D = 32'h0040_0010; branch_E = 1'b0; pc_E = '0;
    target_E = '0; ghr_snap_E = '0; actual_take_E = 1'b0; pre_right_E = 1'b1;
    stall_D = 1'b0; stall_E = 1'b0;
    #2;
    check("rst_pred", 32'(pred_take_D), 32'd0);
    check("rst_snap", 32'(ghr_snap_D), 32'd0);
    check("rst_redirect", 32'(redirect_E), 32'd0);
    check("rst_flush", 32'(flush_D), 32'd0);
    check("rst_rpc", redirect_pc_E, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // First prediction after reset
    cycle(1, 32'h0040_0010, 0, 0, 0, 0, 0, 1, 0, 0);

    // Two taken trainings at 0x00400010, then predict it
    repeat (2) cycle(0, 0, 1, 32'h0040_0010, 0, 0, 1, 1, 0, 0);
    cycle(1, 32'h0040_0010, 0, 0, 0, 0, 0, 1, 0, 0);

    // Train to 11, then five not-taken resolutions down to 00
    cycle(0, 0, 1, 32'h0040_0030, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 32'h0040_0030, 0, 0, 1, 1, 0, 0);
    repeat (5) cycle(0, 0, 1, 32'h0040_0030, 0, 0, 0, 1, 0, 0);
    cycle(1, 32'h0040_0030, 0, 0, 0, 0, 0, 1, 0, 0);

    // Mispredicts: taken to target, not-taken past delay slot, wrap-around
    cycle(0, 0, 1, 32'h0040_0040, 32'h0040_0100, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 32'h0040_0020, 32'h0040_0100, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 0, 0);

    // Stalled E holds redirect and training; non-branch with pre_right=0 is inert
    cycle(0, 0, 1, 32'h0040_0050, 32'h0040_0200, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 32'h0040_0050, 32'h0040_0200, 0, 1, 0, 0, 0);

`ifdef BP_GSHARE_EN
    // Same-cycle D shift (predicted taken) and E recovery: E wins
    pc_hit = 32'h0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      pc_r = 32'h0040_0000 + 32'(k) * 4;
      if (pc_hit == 32'h0 && m_ctr[m_idx(pc_r, m_ghr)] >= 2) pc_hit = pc_r;
    end
    cycle(1, pc_hit, 1, 32'h0040_0060, 32'h0040_0300, 8'h5A, 0, 0, 0, 0);
    #2;
    check("gshare_recover_ghr", 32'(ghr_snap_D), 32'h0000_00B4);
    @(negedge clk);
`endif

    // Randomized traffic over a small PC set to force index collisions
    for (int n = 0; n < 400; n++) begin
      pc_r = 32'h0040_0000 + 32'($urandom_range(0, 15)) * 4;
      pc_e = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 1)) * 4
                                          : 32'h0040_0000 + 32'($urandom_range(0, 15)) * 4;
      cycle(1'($urandom), pc_r, 1'($urandom), pc_e, $urandom, GW'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0));
    end

    // Async reset mid-cycle while a mispredict is presented
    branch_E = 1'b1; pre_right_E = 1'b0; stall_E = 1'b0; actual_take_E = 1'b1;
    target_E = 32'h0040_0400; pc_E = 32'h0040_0010; branch_D = 1'b0;
    #2;
    check("pre_reset_redirect", 32'(redirect_E), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_redirect", 32'(redirect_E), 32'd0);
    check("async_rst_flush", 32'(flush_D), 32'd0);
    check("async_rst_rpc", redirect_pc_E, 32'd0);
    check("async_rst_snap", 32'(ghr_snap_D), 32'd0);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 16; k++)
      cycle(1, 32'h0040_0000 + 32'(k) * 4, 0, 0, 0, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
